// File: rtl/block_memory.sv
// block_memory: fixed-latency, block-granular main memory behind the data cache.
// It serves whole-block refills on a read miss and write-through stores with
// per-word enables. Each accepted access completes after LATENCY cycles with a
// one-cycle ready pulse. Busy covers the whole access, including the ready cycle.
module block_memory #(
   parameter int ROWS       = 64,
   parameter int BLOCK_SIZE = 4,
   parameter int LATENCY    = 20
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic [31:0]               Address,
   input  logic                      ReadMiss,
   input  logic                      MemWriteThrough,
   input  logic [BLOCK_SIZE-1:0]     WordEnable,
   input  logic [32*BLOCK_SIZE-1:0]  Write_data,
   output logic [32*BLOCK_SIZE-1:0]  Read_data,
   output logic                      ReadReady,
   output logic                      WriteReady,
   output logic                      Busy
);

   localparam int AW = $clog2(ROWS);
   localparam int CW = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   state_t                    state;
   state_t                    next_state;
   logic [CW-1:0]             count;
   logic [AW-1:0]             base;
   logic [AW-1:0]             cap_base;
   logic                      cap_write;
   logic [BLOCK_SIZE-1:0]     cap_we;
   logic [32*BLOCK_SIZE-1:0]  cap_data;
   logic                      fire;
   logic                      unused_addr_bits;

   // Backing store. It is not cleared by Rst, so its contents survive a reset.
   logic [31:0] mem [ROWS] = '{default: 32'd0};

   // The word index is taken modulo ROWS, so out-of-range addresses wrap.
   // The low word bits are masked to reach the block base.
   assign base             = Address[AW+1:2] & ~AW'(BLOCK_SIZE - 1);
   assign unused_addr_bits = ^{Address[31:AW+2], Address[1:0]};

   // The access happens on the edge where WAIT sees the counter at zero.
   assign fire = (state == WAIT) && (count == '0);

   // Ready pulses come from DONE, which lasts exactly one cycle.
   // Busy covers every non-idle cycle.
   assign ReadReady  = (state == DONE) && !cap_write;
   assign WriteReady = (state == DONE) && cap_write;
   assign Busy       = (state != IDLE);

   // State register. Reset aborts any access in flight.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state. Requests are only looked at in IDLE.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (ReadMiss || MemWriteThrough) next_state = WAIT;
         WAIT: if (count == '0) next_state = DONE;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Capture the request, count down the latency, and load the read block.
   // When both requests arrive together the write wins. The read stays on its
   // line and is picked up on the next return to IDLE.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         count     <= '0;
         cap_base  <= '0;
         cap_write <= 1'b0;
         cap_we    <= '0;
         cap_data  <= '0;
         Read_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ReadMiss || MemWriteThrough) begin
                  cap_write <= MemWriteThrough;
                  cap_base  <= base;
                  count     <= CW'(LATENCY - 1);
                  if (MemWriteThrough) begin
                     cap_we   <= WordEnable;
                     cap_data <= Write_data;
                  end
               end
            end
            WAIT: begin
               if (count != '0) begin
                  count <= count - CW'(1);
               end else if (!cap_write) begin
                  for (int i = 0; i < BLOCK_SIZE; i++) begin
                     Read_data[32*i +: 32] <= mem[cap_base | AW'(i)];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Commit the enabled words of a captured write. A reset on the same edge
   // cancels the commit.
   always_ff @(posedge Clk) begin
      if (!Rst && fire && cap_write) begin
         for (int i = 0; i < BLOCK_SIZE; i++) begin
            if (cap_we[i]) begin
               mem[cap_base | AW'(i)] <= cap_data[32*i +: 32];
            end
         end
      end
   end

endmodule

// File: tb/tb_block_memory.sv
// Testbench for block_memory. One instance uses the default 20-cycle latency.
// A second instance uses LATENCY=1 and covers the address wrap case.
module tb_block_memory;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [31:0]  address = '0;
   logic         read_miss = 1'b0;
   logic         write_through = 1'b0;
   logic [3:0]   word_enable = '0;
   logic [127:0] write_data = '0;
   logic [127:0] read_data;
   logic         read_ready;
   logic         write_ready;
   logic         busy;

   logic [31:0]  address_b = '0;
   logic         read_miss_b = 1'b0;
   logic         write_through_b = 1'b0;
   logic [3:0]   word_enable_b = '0;
   logic [127:0] write_data_b = '0;
   logic [127:0] read_data_b;
   logic         read_ready_b;
   logic         write_ready_b;
   logic         busy_b;

   int errors = 0;
   int checks = 0;

   localparam logic [127:0] PRE    = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
   localparam logic [127:0] ALL_FF = {4{32'h000000FF}};
   localparam logic [127:0] PART   = {32'h44, 32'h33, 32'h22, 32'h11};
   localparam logic [127:0] PART_Q = {32'hFF, 32'h33, 32'hFF, 32'h11};
   localparam logic [127:0] D_SIM  = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
   localparam logic [127:0] D0     = 128'h50505053_50505052_50505051_50505050;
   localparam logic [127:0] D1     = 128'h40404043_40404042_40404041_40404040;
   localparam logic [127:0] D2     = 128'hBAD0BAD3_BAD0BAD2_BAD0BAD1_BAD0BAD0;
   localparam logic [127:0] D_OLD  = 128'h60606063_60606062_60606061_60606060;
   localparam logic [127:0] D3     = 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000;
   localparam logic [127:0] D_W    = 128'h0B0B0003_0B0B0002_0B0B0001_0B0B0000;

   block_memory u_dut (
      .Clk             (clk),
      .Rst             (rst),
      .Address         (address),
      .ReadMiss        (read_miss),
      .MemWriteThrough (write_through),
      .WordEnable      (word_enable),
      .Write_data      (write_data),
      .Read_data       (read_data),
      .ReadReady       (read_ready),
      .WriteReady      (write_ready),
      .Busy            (busy)
   );

   block_memory #(.ROWS(64), .BLOCK_SIZE(4), .LATENCY(1)) u_dut_b (
      .Clk             (clk),
      .Rst             (rst),
      .Address         (address_b),
      .ReadMiss        (read_miss_b),
      .MemWriteThrough (write_through_b),
      .WordEnable      (word_enable_b),
      .Write_data      (write_data_b),
      .Read_data       (read_data_b),
      .ReadReady       (read_ready_b),
      .WriteReady      (write_ready_b),
      .Busy            (busy_b)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one request and pass its acceptance edge, then drop the request lines.
   task automatic issue(input bit use_b, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [3:0] we,
                        input logic [127:0] d);
      if (use_b) begin
         address_b = a; word_enable_b = we; write_data_b = d;
         read_miss_b = rd; write_through_b = wr;
      end else begin
         address = a; word_enable = we; write_data = d;
         read_miss = rd; write_through = wr;
      end
      tick();
      if (use_b) begin
         read_miss_b = 1'b0; write_through_b = 1'b0;
      end else begin
         read_miss = 1'b0; write_through = 1'b0;
      end
   endtask

   // Count edges until the wanted ready pulse appears.
   // Returns -1 on timeout and -2 if the other ready pulse shows up.
   task automatic wait_ready(input bit use_b, input bit want_wr, output int edges);
      logic rr, wr;
      edges = -1;
      for (int e = 1; e <= 60; e++) begin
         tick();
         rr = use_b ? read_ready_b : read_ready;
         wr = use_b ? write_ready_b : write_ready;
         if ((want_wr ? rr : wr) == 1'b1) begin
            edges = -2;
            break;
         end
         if ((want_wr ? wr : rr) == 1'b1) begin
            edges = e;
            break;
         end
      end
   endtask

   task automatic do_write(input bit use_b, input logic [31:0] a,
                           input logic [3:0] we, input logic [127:0] d,
                           output int edges);
      issue(use_b, 1'b0, 1'b1, a, we, d);
      wait_ready(use_b, 1'b1, edges);
      tick();
   endtask

   task automatic do_read(input bit use_b, input logic [31:0] a,
                          output int edges, output logic [127:0] q);
      issue(use_b, 1'b1, 1'b0, a, 4'h0, '0);
      wait_ready(use_b, 1'b0, edges);
      q = use_b ? read_data_b : read_data;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (read_data !== 128'd0) begin errors++; $display("[TB] FAIL reset_read_data: got %h want 0", read_data); end
      checks++; if (read_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_read_ready: got %b want 0", read_ready); end
      checks++; if (write_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_write_ready: got %b want 0", write_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      checks++; if ({busy_b, read_ready_b, write_ready_b} !== 3'b000) begin errors++; $display("[TB] FAIL reset_b_flags: got %b want 000", {busy_b, read_ready_b, write_ready_b}); end
   endtask

   task automatic test_read_latency();
      int edges;
      do_write(1'b0, 32'h10, 4'hF, PRE, edges);
      checks++; if (edges !== 20) begin errors++; $display("[TB] FAIL preload_latency: got %0d want 20", edges); end
      issue(1'b0, 1'b1, 1'b0, 32'h14, 4'h0, '0);
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL read_busy_accept: got %b want 1", busy); end
      wait_ready(1'b0, 1'b0, edges);
      checks++; if (edges !== 20) begin errors++; $display("[TB] FAIL read_latency: got %0d want 20", edges); end
      checks++; if (read_data !== PRE) begin errors++; $display("[TB] FAIL read_data: got %h want %h", read_data, PRE); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL read_busy_ready: got %b want 1", busy); end
      tick();
      checks++; if (read_ready !== 1'b0) begin errors++; $display("[TB] FAIL read_pulse_width: got %b want 0", read_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL read_busy_after: got %b want 0", busy); end
   endtask

   task automatic test_partial_write();
      int edges;
      logic [127:0] q;
      do_write(1'b0, 32'h20, 4'hF, ALL_FF, edges);
      do_write(1'b0, 32'h20, 4'b0101, PART, edges);
      checks++; if (edges !== 20) begin errors++; $display("[TB] FAIL partial_write_latency: got %0d want 20", edges); end
      do_read(1'b0, 32'h20, edges, q);
      checks++; if (q !== PART_Q) begin errors++; $display("[TB] FAIL partial_write_data: got %h want %h", q, PART_Q); end
      do_write(1'b0, 32'h24, 4'b0000, D2, edges);
      checks++; if (edges !== 20) begin errors++; $display("[TB] FAIL zero_enable_ready: got %0d want 20", edges); end
      do_read(1'b0, 32'h20, edges, q);
      checks++; if (q !== PART_Q) begin errors++; $display("[TB] FAIL zero_enable_data: got %h want %h", q, PART_Q); end
   endtask

   task automatic test_back_to_back();
      int edges;
      address = 32'h30; word_enable = 4'hF; write_data = D_SIM;
      read_miss = 1'b1; write_through = 1'b1;
      tick();
      write_through = 1'b0;
      wait_ready(1'b0, 1'b1, edges);
      checks++; if (edges !== 20) begin errors++; $display("[TB] FAIL arb_write_first: got %0d want 20", edges); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL arb_idle_gap: got busy %b want 0", busy); end
      tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL arb_read_accept: got busy %b want 1", busy); end
      read_miss = 1'b0;
      wait_ready(1'b0, 1'b0, edges);
      checks++; if (edges !== 20) begin errors++; $display("[TB] FAIL arb_read_latency: got %0d want 20", edges); end
      checks++; if (read_data !== D_SIM) begin errors++; $display("[TB] FAIL arb_read_data: got %h want %h", read_data, D_SIM); end
      tick();
   endtask

   task automatic test_ignore_mid_wait();
      int edges;
      int wr_pulses;
      int rd_pulses;
      int ready_edge;
      logic [127:0] q;
      do_write(1'b0, 32'h50, 4'hF, D0, edges);
      issue(1'b0, 1'b0, 1'b1, 32'h40, 4'hF, D1);
      wr_pulses = 0; rd_pulses = 0; ready_edge = -1;
      for (int e = 1; e <= 25; e++) begin
         if (e == 3) write_through = 1'b1;
         if (e == 4) write_through = 1'b0;
         if (e == 5) begin address = 32'h50; write_data = D2; read_miss = 1'b1; end
         if (e == 8) read_miss = 1'b0;
         tick();
         if (write_ready) begin wr_pulses++; ready_edge = e; end
         if (read_ready) rd_pulses++;
      end
      checks++; if (wr_pulses !== 1) begin errors++; $display("[TB] FAIL ignore_write_pulses: got %0d want 1", wr_pulses); end
      checks++; if (ready_edge !== 20) begin errors++; $display("[TB] FAIL ignore_ready_edge: got %0d want 20", ready_edge); end
      checks++; if (rd_pulses !== 0) begin errors++; $display("[TB] FAIL ignore_read_pulses: got %0d want 0", rd_pulses); end
      do_read(1'b0, 32'h40, edges, q);
      checks++; if (q !== D1) begin errors++; $display("[TB] FAIL ignore_captured_data: got %h want %h", q, D1); end
      do_read(1'b0, 32'h50, edges, q);
      checks++; if (q !== D0) begin errors++; $display("[TB] FAIL ignore_other_block: got %h want %h", q, D0); end
   endtask

   task automatic test_reset_abort();
      int edges;
      int early;
      logic [127:0] q;
      do_write(1'b0, 32'h60, 4'hF, D_OLD, edges);
      issue(1'b0, 1'b0, 1'b1, 32'h60, 4'hF, D3);
      early = 0;
      for (int e = 1; e <= 9; e++) begin
         tick();
         if (write_ready || read_ready) early++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (early !== 0) begin errors++; $display("[TB] FAIL abort_early_ready: got %0d want 0", early); end
      checks++; if ({busy, write_ready, read_ready} !== 3'b000) begin errors++; $display("[TB] FAIL abort_flags: got %b want 000", {busy, write_ready, read_ready}); end
      checks++; if (read_data !== 128'd0) begin errors++; $display("[TB] FAIL abort_read_data: got %h want 0", read_data); end
      issue(1'b0, 1'b1, 1'b0, 32'h60, 4'h0, '0);
      wait_ready(1'b0, 1'b0, edges);
      checks++; if (edges !== 20) begin errors++; $display("[TB] FAIL abort_next_latency: got %0d want 20", edges); end
      q = read_data;
      checks++; if (q !== D_OLD) begin errors++; $display("[TB] FAIL abort_mem_unchanged: got %h want %h", q, D_OLD); end
      tick();
   endtask

   task automatic test_wrap_latency1();
      int edges;
      logic [127:0] q;
      do_write(1'b1, 32'h0, 4'hF, D_W, edges);
      checks++; if (edges !== 1) begin errors++; $display("[TB] FAIL lat1_write: got %0d want 1", edges); end
      issue(1'b1, 1'b1, 1'b0, 32'h104, 4'h0, '0);
      checks++; if (busy_b !== 1'b1) begin errors++; $display("[TB] FAIL lat1_busy: got %b want 1", busy_b); end
      wait_ready(1'b1, 1'b0, edges);
      q = read_data_b;
      checks++; if (edges !== 1) begin errors++; $display("[TB] FAIL lat1_read: got %0d want 1", edges); end
      checks++; if (q !== D_W) begin errors++; $display("[TB] FAIL wrap_data: got %h want %h", q, D_W); end
      tick();
      checks++; if (busy_b !== 1'b0) begin errors++; $display("[TB] FAIL lat1_busy_after: got %b want 0", busy_b); end
   endtask

   // Run every scenario in order and report the totals.
   initial begin
      test_reset();
      test_read_latency();
      test_partial_write();
      test_back_to_back();
      test_ignore_mid_wait();
      test_reset_abort();
      test_wrap_latency1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
